cnn_prog_loader: RTL

Host-side write port for the CNN coprocessor. It accepts a byte stream of command packets and writes their payload into instruction memory (32-bit words), image memory (N-bit pixels) or filter memory (N-bit weights). It holds the pipeline in reset while loading and releases it on a RUN command. The pipeline core only reads these memories; this block is the writer that fills them.

---
 rtl/cnn_prog_loader_if.sv | 38 +++
 rtl/cnn_prog_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cnn_prog_loader_if.sv
// Host byte stream plus memory write bus and pipeline control of the CNN program loader.
// slave is the loader's view; master is the host/memory side.
interface cnn_prog_loader_if #(
    parameter int N    = 8,
    parameter int I_AW = 8,
    parameter int IW   = 32,
    parameter int M_AW = 10,
    parameter int F_AW = 3
);
    logic [N-1:0]    in_data;
    logic            in_valid;
    logic            in_ready;
    logic            mem_stall;
    logic            imem_we;
    logic [I_AW-1:0] imem_addr;
    logic [IW-1:0]   imem_wdata;
    logic            dmem_we;
    logic [M_AW-1:0] dmem_addr;
    logic            fmem_we;
    logic [F_AW-1:0] fmem_addr;
    logic [N-1:0]    mem_wdata;
    logic            core_hold;
    logic            run;
    logic            done;
    logic            err;

    modport slave (
        input  in_data, in_valid, mem_stall,
        output in_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr,
               fmem_we, fmem_addr, mem_wdata, core_hold, run, done, err
    );

    modport master (
        output in_data, in_valid, mem_stall,
        input  in_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr,
               fmem_we, fmem_addr, mem_wdata, core_hold, run, done, err
    );
endinterface

// File: rtl/cnn_prog_loader.sv
// Parses LOAD_I/LOAD_D/LOAD_F/RUN command packets from a byte stream and issues
// registered writes into instruction, image and filter memory; controls pipeline hold/run.
module cnn_prog_loader #(
    parameter int N    = 8,
    parameter int I_AW = 8,
    parameter int IW   = 32,
    parameter int M_AW = 10,
    parameter int F_AW = 3
) (
    input  logic               clock,
    input  logic               reset,
    cnn_prog_loader_if.slave   bus
);
    localparam int AW = (I_AW > M_AW) ? ((I_AW > F_AW) ? I_AW : F_AW)
                                      : ((M_AW > F_AW) ? M_AW : F_AW);
    localparam logic [N-1:0] CMD_I   = N'(8'h01);
    localparam logic [N-1:0] CMD_D   = N'(8'h02);
    localparam logic [N-1:0] CMD_F   = N'(8'h03);
    localparam logic [N-1:0] CMD_RUN = N'(8'h04);
    localparam logic [1:0]   K_I     = 2'd1;
    localparam logic [1:0]   K_D     = 2'd2;
    localparam logic [1:0]   K_F     = 2'd3;
    localparam logic [15:0]  D_CNT_MASK = 16'((17'd1 << M_AW) - 17'd1);

    typedef enum logic [2:0] {IDLE, A_HI, A_LO, C_HI, C_LO, PAYLOAD} state_t;

    state_t          state_q, state_d;
    logic [1:0]      cmd_q, cmd_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [1:0]      bidx_q, bidx_d;
    logic [3*N-1:0]  word_q, word_d;
    logic            imem_we_q, imem_we_d;
    logic [I_AW-1:0] imem_addr_q, imem_addr_d;
    logic [IW-1:0]   imem_wdata_q, imem_wdata_d;
    logic            dmem_we_q, dmem_we_d;
    logic [M_AW-1:0] dmem_addr_q, dmem_addr_d;
    logic            fmem_we_q, fmem_we_d;
    logic [F_AW-1:0] fmem_addr_q, fmem_addr_d;
    logic [N-1:0]    mem_wdata_q, mem_wdata_d;
    logic            core_hold_q, core_hold_d;
    logic            run_q, run_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            stall_s;
    logic            accept_s;
    logic [15:0]     hdr_cnt_s;

    // Next-state: header parsing, payload packing, write issue and stall hold.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        hi_d         = hi_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        bidx_d       = bidx_q;
        word_d       = word_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_addr_d  = dmem_addr_q;
        fmem_addr_d  = fmem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_hold_d  = core_hold_q;
        run_d        = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        hdr_cnt_s    = (cmd_q == K_D) ? (16'({hi_q, bus.in_data}) & D_CNT_MASK)
                                      : 16'(bus.in_data);
        stall_s      = (imem_we_q | dmem_we_q | fmem_we_q) & bus.mem_stall;
        accept_s     = bus.in_valid & ~stall_s;

        // A stalled write keeps strobe, address and data; otherwise it retires now.
        if (stall_s) begin
            imem_we_d = imem_we_q;
            dmem_we_d = dmem_we_q;
            fmem_we_d = fmem_we_q;
        end else begin
            imem_we_d = 1'b0;
            dmem_we_d = 1'b0;
            fmem_we_d = 1'b0;
        end

        if (accept_s) begin
            case (state_q)
                IDLE: begin
                    case (bus.in_data)
                        CMD_I:   begin cmd_d = K_I; state_d = A_LO; core_hold_d = 1'b1; end
                        CMD_D:   begin cmd_d = K_D; state_d = A_HI; core_hold_d = 1'b1; end
                        CMD_F:   begin cmd_d = K_F; state_d = A_LO; core_hold_d = 1'b1; end
                        CMD_RUN: begin run_d = 1'b1; done_d = 1'b1; core_hold_d = 1'b0; end
                        default: err_d = 1'b1;
                    endcase
                end
                A_HI: begin
                    hi_d    = bus.in_data;
                    state_d = A_LO;
                end
                A_LO: begin
                    addr_d  = (cmd_q == K_D) ? AW'({hi_q, bus.in_data}) : AW'(bus.in_data);
                    state_d = (cmd_q == K_D) ? C_HI : C_LO;
                end
                C_HI: begin
                    hi_d    = bus.in_data;
                    state_d = C_LO;
                end
                C_LO: begin
                    cnt_d  = hdr_cnt_s;
                    bidx_d = 2'd0;
                    if (hdr_cnt_s == 16'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if ((cmd_q == K_I) && (bidx_q != 2'd3)) begin
                        word_d[bidx_q*N +: N] = bus.in_data;
                        bidx_d = bidx_q + 2'd1;
                    end else begin
                        // Addresses are truncated per memory, so the shared counter wraps for free.
                        case (cmd_q)
                            K_I: begin
                                imem_we_d    = 1'b1;
                                imem_addr_d  = addr_q[I_AW-1:0];
                                imem_wdata_d = {bus.in_data, word_q};
                                bidx_d       = 2'd0;
                            end
                            K_D: begin
                                dmem_we_d   = 1'b1;
                                dmem_addr_d = addr_q[M_AW-1:0];
                                mem_wdata_d = bus.in_data;
                            end
                            default: begin
                                fmem_we_d   = 1'b1;
                                fmem_addr_d = addr_q[F_AW-1:0];
                                mem_wdata_d = bus.in_data;
                            end
                        endcase
                        addr_d = addr_q + AW'(1'b1);
                        cnt_d  = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            cmd_q        <= 2'd0;
            hi_q         <= '0;
            addr_q       <= '0;
            cnt_q        <= 16'd0;
            bidx_q       <= 2'd0;
            word_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            fmem_we_q    <= 1'b0;
            fmem_addr_q  <= '0;
            mem_wdata_q  <= '0;
            core_hold_q  <= 1'b1;
            run_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            hi_q         <= hi_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            bidx_q       <= bidx_d;
            word_q       <= word_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            fmem_we_q    <= fmem_we_d;
            fmem_addr_q  <= fmem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_hold_q  <= core_hold_d;
            run_q        <= run_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready   = ~stall_s;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.fmem_we    = fmem_we_q;
    assign bus.fmem_addr  = fmem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.core_hold  = core_hold_q;
    assign bus.run        = run_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule
